cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among the functional units (ALU, select, load, …). Each FU output stage raises a CDB request with its ROB id and result value. The arbiter grants exactly one requester per cycle and drives the registered broadcast seen by the reservation stations and ROB. It also provides the `cdb_transmit` grant that each FU output stage waits on.

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// ---------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB). The reservation
// stations, the ROB and the CDB arbiter all import this package so they
// agree on the shape of the broadcast.
//   ROBID_W   : ROB id width carried on the bus
//   DATA_W    : result width carried on the bus
//   cdb_bus_t : packed {valid, id, val} broadcast word
// ---------------------------------------------------------------------------
package cdb_pkg;

   localparam int ROBID_W = 4;
   localparam int DATA_W  = 8;

   typedef struct packed {
      logic               valid;
      logic [ROBID_W-1:0] id;
      logic [DATA_W-1:0]  val;
   } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Generic, purely combinational round-robin grant logic. The search begins
// at index ptr and moves upward, wrapping at N; the first set request wins.
// Ports:
//   req       in  N      request vector
//   ptr       in  PTR_W  priority pointer, must be in 0..N-1
//   enable    in  1      when low no grant is produced
//   grant     out N      one-hot grant (all zero when nothing is granted)
//   grant_idx out PTR_W  index of the granted requester (0 when none)
//   any_grant out 1      a grant was produced this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
   import cdb_pkg::*;
#(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             enable,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any_grant
);

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      if (enable) begin
         for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single subtraction is enough to wrap;
            // this keeps non-power-of-two N correct.
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_grant && req[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = PTR_W'(idx);
               any_grant  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus among NUM_REQ functional units. One
// requester is granted per cycle (same-cycle grant), and the winner's ROB id
// and result are registered onto the broadcast one cycle later.
// Ports:
//   clk       in  1               rising-edge clock
//   rst       in  1               synchronous active-high reset
//   flush     in  1               squashes the grant and the broadcast
//   req       in  NUM_REQ         per-FU request (cdb_transmit_out)
//   req_id    in  NUM_REQ*ID_W    per-FU ROB id, FU i at [i*ID_W +: ID_W]
//   req_val   in  NUM_REQ*DATA_W  per-FU result, FU i at [i*DATA_W +: DATA_W]
//   grant     out NUM_REQ         one-hot grant (cdb_transmit)
//   cdb_valid out 1               broadcast valid
//   cdb_id    out ID_W            broadcast ROB id
//   cdb_val   out DATA_W          broadcast value
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 4,
   parameter int DATA_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ID_W-1:0]   req_id,
   input  logic [NUM_REQ*DATA_W-1:0] req_val,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      cdb_valid,
   output logic [ID_W-1:0]           cdb_id,
   output logic [DATA_W-1:0]         cdb_val
);
   import cdb_pkg::*;

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_nxt;
   logic [PTR_W-1:0]  grant_idx;
   logic              any_grant;
   logic              enable;
   logic [ID_W-1:0]   sel_id;
   logic [DATA_W-1:0] sel_val;

   // Reset and flush both suppress the grant, so no FU believes it was
   // served in a cycle whose broadcast is going to be discarded.
   assign enable = ~rst & ~flush;

   rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req       (req),
      .ptr       (ptr),
      .enable    (enable),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign sel_id  = req_id[int'(grant_idx)*ID_W +: ID_W];
   assign sel_val = req_val[int'(grant_idx)*DATA_W +: DATA_W];

   // Explicit wrap: NUM_REQ need not be a power of two.
   assign ptr_nxt = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

   // ---- stage boundary: grant -> registered broadcast ----
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         cdb_valid <= 1'b0;
         cdb_id    <= '0;
         cdb_val   <= '0;
      end else begin
         cdb_valid <= any_grant;
         if (any_grant) begin
            ptr     <= ptr_nxt;
            cdb_id  <= sel_id;
            cdb_val <= sel_val;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   typedef struct packed {
      logic [3:0] id;
      logic [7:0] val;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [3:0]  req;
   logic [15:0] req_id;
   logic [31:0] req_val;
   logic [3:0]  grant;
   logic        cdb_valid;
   logic [3:0]  cdb_id;
   logic [7:0]  cdb_val;

   logic [2:0]  req3;
   logic [11:0] req_id3;
   logic [23:0] req_val3;
   logic [2:0]  grant3;
   logic        cdb_valid3;
   logic [3:0]  cdb_id3;
   logic [7:0]  cdb_val3;

   bus_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(4), .ID_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req(req), .req_id(req_id),
      .req_val(req_val), .grant(grant), .cdb_valid(cdb_valid),
      .cdb_id(cdb_id), .cdb_val(cdb_val)
   );

   cdb_arbiter #(.NUM_REQ(3), .ID_W(4), .DATA_W(8)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .req(req3), .req_id(req_id3),
      .req_val(req_val3), .grant(grant3), .cdb_valid(cdb_valid3),
      .cdb_id(cdb_id3), .cdb_val(cdb_val3)
   );

   // Scoreboard monitor: every broadcast must match the oldest expected grant.
   always @(negedge clk) begin
      if (cdb_valid === 1'b1) begin
         bus_t e;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got id=%0d val=%0h, expected no broadcast", cdb_id, cdb_val);
         end else begin
            e = sb.pop_front();
            if (cdb_id !== e.id || cdb_val !== e.val) begin
               bad++;
               $display("FAIL sb_bus: got id=%0d val=%0h, expected id=%0d val=%0h", cdb_id, cdb_val, e.id, e.val);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] id, input logic [7:0] val);
      bus_t e;
      e.id  = id;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic set_fu(input int i, input logic [3:0] id, input logic [7:0] val);
      req_id[i*4 +: 4]  = id;
      req_val[i*8 +: 8] = val;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; req = 4'b1111; req3 = 3'b111;
      #1;
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b, expected 0000", grant); end
      total++;
      if (cdb_valid !== 1'b0 || cdb_id !== 4'd0 || cdb_val !== 8'd0) begin
         bad++; $display("FAIL reset_bus: got v=%b id=%0d val=%0h, expected 0/0/0", cdb_valid, cdb_id, cdb_val);
      end
      total++;
      if (dut.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr: got %0d, expected 0", dut.ptr); end
      step();
      rst = 1'b0; req = 4'b0000; req3 = 3'b000;
      #1;
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL idle_grant: got %b, expected 0000", grant); end
   endtask

   task automatic test_single();
      set_fu(2, 4'd5, 8'h3C);
      req = 4'b0100;
      #1;
      total++;
      if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b, expected 0100", grant); end
      push(4'd5, 8'h3C);
      step();
      req = 4'b0000;
      #1;
      total++;
      if (cdb_valid !== 1'b1 || cdb_id !== 4'd5 || cdb_val !== 8'h3C) begin
         bad++; $display("FAIL single_bus: got v=%b id=%0d val=%0h, expected 1/5/3c", cdb_valid, cdb_id, cdb_val);
      end
      total++;
      if (dut.ptr !== 2'd3) begin bad++; $display("FAIL single_ptr: got %0d, expected 3", dut.ptr); end
      step();
   endtask

   task automatic test_rotation();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_fu(i, 4'(i + 1), 8'(8'h10 + i));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] exp_g;
         exp_g = 4'b0001 << (k % 4);
         #1;
         total++;
         if (grant !== exp_g) begin bad++; $display("FAIL rotation_grant[%0d]: got %b, expected %b", k, grant, exp_g); end
         push(4'((k % 4) + 1), 8'(8'h10 + (k % 4)));
         step();
      end
      req = 4'b0000;
      total++;
      if (dut.ptr !== 2'd1) begin bad++; $display("FAIL rotation_ptr: got %0d, expected 1", dut.ptr); end
   endtask

   task automatic test_wrap_skip();
      req = 4'b0100;
      #1;
      push(4'd3, 8'h12);
      step();
      total++;
      if (dut.ptr !== 2'd3) begin bad++; $display("FAIL wrap_ptr3: got %0d, expected 3", dut.ptr); end
      req = 4'b1001;
      #1;
      total++;
      if (grant !== 4'b1000) begin bad++; $display("FAIL wrap_grant3: got %b, expected 1000", grant); end
      push(4'd4, 8'h13);
      step();
      #1;
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_grant0: got %b, expected 0001", grant); end
      push(4'd1, 8'h10);
      step();
      req = 4'b0001;
      #1;
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL skip_grant0: got %b, expected 0001", grant); end
      push(4'd1, 8'h10);
      step();
      req = 4'b0000;
   endtask

   task automatic test_flush();
      req = 4'b0010;
      #1;
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL flush_pre_grant: got %b, expected 0010", grant); end
      push(4'd2, 8'h11);
      step();
      flush = 1'b1; req = 4'b0100;
      #1;
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL flush_grant: got %b, expected 0000", grant); end
      step();
      flush = 1'b0;
      #1;
      total++;
      if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b, expected 0", cdb_valid); end
      total++;
      if (dut.ptr !== 2'd2) begin bad++; $display("FAIL flush_ptr: got %0d, expected 2", dut.ptr); end
      total++;
      if (grant !== 4'b0100) begin bad++; $display("FAIL flush_after_grant: got %b, expected 0100", grant); end
      push(4'd3, 8'h12);
      step();
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      req = 4'b0010;
      #1;
      push(4'd2, 8'h11);
      step();
      total++;
      if (dut.ptr !== 2'd2) begin bad++; $display("FAIL rmid_ptr_pre: got %0d, expected 2", dut.ptr); end
      req = 4'b1111; rst = 1'b1;
      #1;
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_grant: got %b, expected 0000", grant); end
      step();
      rst = 1'b0;
      #1;
      total++;
      if (cdb_valid !== 1'b0 || dut.ptr !== 2'd0) begin
         bad++; $display("FAIL rmid_state: got v=%b ptr=%0d, expected 0/0", cdb_valid, dut.ptr);
      end
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_first: got %b, expected 0001", grant); end
      push(4'd1, 8'h10);
      step();
      // reset together with flush: reset wins and clears the pointer
      rst = 1'b1; flush = 1'b1;
      #1;
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL rstflush_grant: got %b, expected 0000", grant); end
      step();
      rst = 1'b0; flush = 1'b0; req = 4'b0000;
      #1;
      total++;
      if (dut.ptr !== 2'd0 || cdb_valid !== 1'b0) begin
         bad++; $display("FAIL rstflush_state: got ptr=%0d v=%b, expected 0/0", dut.ptr, cdb_valid);
      end
   endtask

   task automatic test_back_to_back();
      req = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_fu(0, 4'(k + 8), 8'(8'hA0 + k));
         #1;
         total++;
         if (grant !== 4'b0001) begin bad++; $display("FAIL b2b_grant[%0d]: got %b, expected 0001", k, grant); end
         push(4'(k + 8), 8'(8'hA0 + k));
         step();
      end
      req = 4'b0000;
      total++;
      if (dut.ptr !== 2'd1) begin bad++; $display("FAIL b2b_ptr: got %0d, expected 1", dut.ptr); end
   endtask

   task automatic test_n3();
      req_id3 = 12'h321; req_val3 = 24'h332211;
      req3 = 3'b111;
      for (int k = 0; k < 5; k++) begin
         logic [2:0] exp_g;
         exp_g = 3'b001 << (k % 3);
         #1;
         total++;
         if (grant3 !== exp_g || dut3.ptr !== 2'(k % 3)) begin
            bad++; $display("FAIL n3_grant[%0d]: got grant=%b ptr=%0d, expected %b/%0d", k, grant3, dut3.ptr, exp_g, k % 3);
         end
         step();
      end
      req3 = 3'b000;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req = '0; req_id = '0; req_val = '0;
      req3 = '0; req_id3 = '0; req_val3 = '0;
      step();
      step();
      test_reset();
      test_single();
      test_rotation();
      test_wrap_skip();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_n3();
      step();
      step();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending, expected 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
